// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and load/store ports
// Optional round-robin tie-breaking is enabled by defining MEM_ARB_RR_EN.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_dm_req,
    input  logic                i_dm_we,
    input  logic [ADDR_W-1:0]   i_dm_addr,
    input  logic [DATA_W-1:0]   i_dm_wdata,
    input  logic [DATA_W/8-1:0] i_dm_be,
    output logic                o_dm_gnt,
    output logic                o_dm_rvalid,
    output logic [DATA_W-1:0]   o_dm_rdata,
    output logic                o_mem_en,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_be,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_busy
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       owner_dm;
    logic       pick_dm;
    logic       can_grant;
    logic       rd_done;

`ifdef MEM_ARB_RR_EN
    // 1 when the data port won the most recent grant; reset means fetch went last
    logic       last_dm;
`endif

    always_comb begin
        pick_dm = i_dm_req;
`ifdef MEM_ARB_RR_EN
        if (i_dm_req && i_if_req)
            pick_dm = !last_dm;
`endif
        can_grant = (state == IDLE) && !i_rst;
        o_dm_gnt  = can_grant && i_dm_req && pick_dm;
        o_if_gnt  = can_grant && i_if_req && !pick_dm;

        o_mem_en    = o_dm_gnt || o_if_gnt;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_be    = '0;
        if (o_dm_gnt) begin
            o_mem_we    = i_dm_we;
            o_mem_addr  = i_dm_addr;
            o_mem_wdata = i_dm_wdata;
            o_mem_be    = i_dm_be;
        end else if (o_if_gnt) begin
            o_mem_addr  = i_if_addr;
            o_mem_be    = {BE_W{1'b1}};
        end

        // Read data is valid in the cycle the countdown sits at zero
        rd_done     = (state == WAIT) && (cnt == 4'd0) && !i_rst;
        o_dm_rvalid = rd_done && owner_dm;
        o_if_rvalid = rd_done && !owner_dm;
        o_dm_rdata  = o_dm_rvalid ? i_mem_rdata : '0;
        o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
        o_busy      = (state == WAIT) && !i_rst;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            owner_dm <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_dm  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (o_dm_gnt && !i_dm_we) begin
                        state    <= WAIT;
                        cnt      <= LAT_M1;
                        owner_dm <= 1'b1;
                    end else if (o_if_gnt) begin
                        state    <= WAIT;
                        cnt      <= LAT_M1;
                        owner_dm <= 1'b0;
                    end
`ifdef MEM_ARB_RR_EN
                    if (o_dm_gnt || o_if_gnt)
                        last_dm <= o_dm_gnt;
`endif
                end
                WAIT: begin
                    if (cnt == 4'd0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter (MEM_LATENCY=2)
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
        .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
        .i_dm_wdata(dm_wdata), .i_dm_be(dm_be), .o_dm_gnt(dm_gnt),
        .o_dm_rvalid(dm_rvalid), .o_dm_rdata(dm_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
        .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [3:0]  dm_be;
        logic [31:0] mem_rdata;
        logic        e_if_gnt;
        logic        e_dm_gnt;
        logic        e_mem_en;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
        logic [3:0]  e_mem_be;
        logic        e_if_rvalid;
        logic [31:0] e_if_rdata;
        logic        e_dm_rvalid;
        logic [31:0] e_dm_rdata;
        logic        e_busy;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd, input logic [3:0] db,
                         input logic [31:0] rd);
        if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw;
        dm_addr = da; dm_wdata = dd; dm_be = db; mem_rdata = rd;
    endtask

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] dd, input logic [3:0] db,
                                input logic [31:0] rd, input logic eig, input logic edg,
                                input logic een, input logic ewe, input logic [31:0] ea,
                                input logic [31:0] ewd, input logic [3:0] ebe, input logic eiv,
                                input logic [31:0] eid, input logic edv, input logic [31:0] edd,
                                input logic eb);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw; v.dm_addr = da;
        v.dm_wdata = dd; v.dm_be = db; v.mem_rdata = rd;
        v.e_if_gnt = eig; v.e_dm_gnt = edg; v.e_mem_en = een; v.e_mem_we = ewe;
        v.e_mem_addr = ea; v.e_mem_wdata = ewd; v.e_mem_be = ebe; v.e_if_rvalid = eiv;
        v.e_if_rdata = eid; v.e_dm_rvalid = edv; v.e_dm_rdata = edd; v.e_busy = eb;
        return v;
    endfunction

    initial begin
        string tag;
        string order;
        string exp_order;
        int    gcnt;
        int    gcyc[4];

        //          ifr ifaddr     dmr we dmaddr     wdata        be    rdata         ig dg en we addr       wdata        be    iv idata         dv ddata         busy
        vecs[0]  = mk(0, 32'h0,     0, 0, 32'h0,     32'h0,       4'h0, 32'h0,        0, 0, 0, 0, 32'h0,     32'h0,       4'h0, 0, 32'h0,        0, 32'h0,        0);
        vecs[1]  = mk(1, 32'h100,   0, 0, 32'h0,     32'h0,       4'h0, 32'h00500093, 1, 0, 1, 0, 32'h100,   32'h0,       4'hF, 0, 32'h0,        0, 32'h0,        0);
        vecs[2]  = mk(1, 32'h104,   0, 0, 32'h0,     32'h0,       4'h0, 32'h00500093, 0, 0, 0, 0, 32'h0,     32'h0,       4'h0, 0, 32'h0,        0, 32'h0,        1);
        vecs[3]  = mk(1, 32'h104,   0, 0, 32'h0,     32'h0,       4'h0, 32'h00500093, 0, 0, 0, 0, 32'h0,     32'h0,       4'h0, 1, 32'h00500093, 0, 32'h0,        1);
        vecs[4]  = mk(1, 32'h104,   0, 0, 32'h0,     32'h0,       4'h0, 32'h0,        1, 0, 1, 0, 32'h104,   32'h0,       4'hF, 0, 32'h0,        0, 32'h0,        0);
        vecs[5]  = mk(0, 32'h0,     0, 0, 32'h0,     32'h0,       4'h0, 32'h0,        0, 0, 0, 0, 32'h0,     32'h0,       4'h0, 0, 32'h0,        0, 32'h0,        1);
        vecs[6]  = mk(0, 32'h0,     1, 1, 32'h200,   32'hDEADBEEF,4'h3, 32'h11112222, 0, 0, 0, 0, 32'h0,     32'h0,       4'h0, 1, 32'h11112222, 0, 32'h0,        1);
        vecs[7]  = mk(0, 32'h0,     1, 1, 32'h200,   32'hDEADBEEF,4'h3, 32'h0,        0, 1, 1, 1, 32'h200,   32'hDEADBEEF,4'h3, 0, 32'h0,        0, 32'h0,        0);
        vecs[8]  = mk(0, 32'h0,     1, 1, 32'h204,   32'h12345678,4'hC, 32'h0,        0, 1, 1, 1, 32'h204,   32'h12345678,4'hC, 0, 32'h0,        0, 32'h0,        0);
        vecs[9]  = mk(0, 32'h0,     1, 0, 32'h300,   32'h0,       4'hF, 32'h0,        0, 1, 1, 0, 32'h300,   32'h0,       4'hF, 0, 32'h0,        0, 32'h0,        0);
        vecs[10] = mk(1, 32'h108,   0, 0, 32'h0,     32'h0,       4'h0, 32'h0,        0, 0, 0, 0, 32'h0,     32'h0,       4'h0, 0, 32'h0,        0, 32'h0,        1);
        vecs[11] = mk(1, 32'h108,   0, 0, 32'h0,     32'h0,       4'h0, 32'hCAFEF00D, 0, 0, 0, 0, 32'h0,     32'h0,       4'h0, 0, 32'h0,        1, 32'hCAFEF00D, 1);
        vecs[12] = mk(1, 32'h108,   0, 0, 32'h0,     32'h0,       4'h0, 32'h0,        1, 0, 1, 0, 32'h108,   32'h0,       4'hF, 0, 32'h0,        0, 32'h0,        0);

        // Reset with both requesters active: nothing granted, outputs quiet
        rst = 1'b1;
        drive(1, 32'h40, 1, 0, 32'h80, 32'h0, 4'hF, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("rst_if_gnt", 32'(if_gnt), 32'h0);
            chk("rst_dm_gnt", 32'(dm_gnt), 32'h0);
            chk("rst_mem_en", 32'(mem_en), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_rvalid", {30'h0, if_rvalid, dm_rvalid}, 32'h0);
        end
        @(negedge clk); rst = 1'b0; #1;
        chk("rel_dm_gnt", 32'(dm_gnt), 32'h1);
        chk("rel_if_gnt", 32'(if_gnt), 32'h0);
        chk("rel_mem_addr", mem_addr, 32'h80);
        drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(negedge clk);

        // Cycle-by-cycle vector table
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].dm_req, vecs[i].dm_we,
                  vecs[i].dm_addr, vecs[i].dm_wdata, vecs[i].dm_be, vecs[i].mem_rdata);
            #1;
            tag = $sformatf("v%0d_", i);
            chk({tag, "if_gnt"},    32'(if_gnt),    32'(vecs[i].e_if_gnt));
            chk({tag, "dm_gnt"},    32'(dm_gnt),    32'(vecs[i].e_dm_gnt));
            chk({tag, "mem_en"},    32'(mem_en),    32'(vecs[i].e_mem_en));
            chk({tag, "mem_we"},    32'(mem_we),    32'(vecs[i].e_mem_we));
            chk({tag, "mem_addr"},  mem_addr,       vecs[i].e_mem_addr);
            chk({tag, "mem_wdata"}, mem_wdata,      vecs[i].e_mem_wdata);
            chk({tag, "mem_be"},    32'(mem_be),    32'(vecs[i].e_mem_be));
            chk({tag, "if_rvalid"}, 32'(if_rvalid), 32'(vecs[i].e_if_rvalid));
            chk({tag, "if_rdata"},  if_rdata,       vecs[i].e_if_rdata);
            chk({tag, "dm_rvalid"}, 32'(dm_rvalid), 32'(vecs[i].e_dm_rvalid));
            chk({tag, "dm_rdata"},  dm_rdata,       vecs[i].e_dm_rdata);
            chk({tag, "busy"},      32'(busy),      32'(vecs[i].e_busy));
        end

        // Contention: both hold reads; last grant above went to fetch
        drive(1, 32'h10C, 1, 0, 32'h400, 32'h0, 4'hF, 32'h0);
        order = "";
        gcnt = 0;
        for (int c = 0; c < 40 && gcnt < 4; c++) begin
            @(negedge clk); #1;
            if (dm_gnt && if_gnt) chk("cont_double_gnt", 32'h1, 32'h0);
            if (dm_gnt || if_gnt) begin
                order = {order, dm_gnt ? "D" : "F"};
                gcyc[gcnt] = c;
                gcnt++;
            end
        end
        chk("cont_grant_count", 32'(gcnt), 32'h4);
`ifdef MEM_ARB_RR_EN
        exp_order = "DFDF";
`else
        exp_order = "DDDD";
`endif
        tests++;
        if (order != exp_order) begin
            fails++;
            $display("FAIL cont_order: got %s expected %s", order, exp_order);
        end
        if (gcnt == 4)
            for (int k = 1; k < 4; k++)
                chk("cont_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'h3);
        drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
        repeat (4) @(negedge clk);

        // Reset during an outstanding load discards it; held fetch granted right after
        drive(0, 32'h0, 1, 0, 32'h500, 32'h0, 4'hF, 32'h5555AAAA);
        #1;
        chk("mid_dm_gnt", 32'(dm_gnt), 32'h1);
        @(negedge clk);
        drive(1, 32'h110, 0, 0, 32'h0, 32'h0, 4'h0, 32'h5555AAAA);
        rst = 1'b1; #1;
        chk("mid_rst_rvalid", 32'(dm_rvalid), 32'h0);
        chk("mid_rst_gnt", 32'(if_gnt), 32'h0);
        @(negedge clk);
        rst = 1'b0; #1;
        chk("mid_after_rvalid", 32'(dm_rvalid), 32'h0);
        chk("mid_after_busy", 32'(busy), 32'h0);
        chk("mid_held_if_gnt", 32'(if_gnt), 32'h1);
        chk("mid_held_addr", mem_addr, 32'h110);
        drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h5555AAAA);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("mid_no_dm_rvalid", 32'(dm_rvalid), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
